// File: rtl/gpi_edge_pkg.sv
// gpi_edge_pkg: register map shared by the GPI edge-capture block and its users.
package gpi_edge_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] ADDR_LEVEL = 5'h00;  // filtered pin levels, read-only
    localparam logic [ADDR_W-1:0] ADDR_RISE  = 5'h01;  // sticky rising edges, write-1-to-clear
    localparam logic [ADDR_W-1:0] ADDR_FALL  = 5'h02;  // sticky falling edges, write-1-to-clear
    localparam logic [ADDR_W-1:0] ADDR_MASK  = 5'h03;  // interrupt enables, read/write

endpackage : gpi_edge_pkg

// File: rtl/gpi_edge_bit.sv
// gpi_edge_bit: one input pin -- two-flop synchronizer, optional debounce filter,
// filtered level and single-cycle edge events aligned with the level update.
// Optional feature: define GPI_EDGE_DEBOUNCE_EN to build the per-pin debounce
// counter; without it the filtered level simply follows the second sync flop.
module gpi_edge_bit
`ifdef GPI_EDGE_DEBOUNCE_EN
#(
    parameter int DB_CYCLES = 4
)
`endif
(
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise_evt,
    output logic fall_evt
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic lvl_q, lvl_d;

`ifdef GPI_EDGE_DEBOUNCE_EN
    localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchronize; accept a new level only after it has held for DB_CYCLES clocks.
    always_comb begin
        s1_d  = pin;
        s2_d  = s1_q;
        lvl_d = lvl_q;
        cnt_d = '0;
        if (s2_q != lvl_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                lvl_d = s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State register; reset also drops any partially counted change.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            lvl_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end
`else
    // Synchronize; the filtered level follows the second sync flop directly.
    always_comb begin
        s1_d  = pin;
        s2_d  = s1_q;
        lvl_d = s2_q;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            lvl_q <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            lvl_q <= lvl_d;
        end
    end
`endif

    // Edge events are taken from the pending level change so the sticky bits
    // in the parent set on the same clock edge that the level register moves.
    assign level    = lvl_q;
    assign rise_evt = ~lvl_q &  lvl_d;
    assign fall_evt =  lvl_q & ~lvl_d;

endmodule : gpi_edge_bit

// File: rtl/gpi_edge.sv
// gpi_edge: W general-purpose inputs with synchronized level, sticky rise/fall
// capture (write-1-to-clear), per-pin interrupt mask and a level irq.
// Optional feature: GPI_EDGE_DEBOUNCE_EN enables a DB_CYCLES debounce per pin.
module gpi_edge
    import gpi_edge_pkg::*;
#(
    parameter int W         = 16,
    parameter int DB_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              read,
    input  logic              write,
    input  logic              cs,
    input  logic [W-1:0]      data_in,
    output logic              irq
);

    // Elaboration-time guard on the parameter ranges the block supports.
    if (W < 1 || W > DATA_W || DB_CYCLES < 1) begin : g_bad_params
        $error("gpi_edge: W must be 1..32 and DB_CYCLES >= 1");
    end

    logic [W-1:0] lvl;
    logic [W-1:0] rise_set;
    logic [W-1:0] fall_set;

    for (genvar i = 0; i < W; i++) begin : g_bit
        gpi_edge_bit
`ifdef GPI_EDGE_DEBOUNCE_EN
        #(
            .DB_CYCLES (DB_CYCLES)
        )
`endif
        u_bit (
            .clock    (clock),
            .reset    (reset),
            .pin      (data_in[i]),
            .level    (lvl[i]),
            .rise_evt (rise_set[i]),
            .fall_evt (fall_set[i])
        );
    end

    logic [W-1:0] rise_q, rise_d;
    logic [W-1:0] fall_q, fall_d;
    logic [W-1:0] mask_q, mask_d;
    logic [W-1:0] rise_clr;
    logic [W-1:0] fall_clr;
    logic         wr_en;

    assign wr_en = cs && write;

    // Register updates; a new edge outranks a same-cycle write-1-to-clear.
    always_comb begin
        rise_clr = (wr_en && address == ADDR_RISE) ? wr_data[W-1:0] : '0;
        fall_clr = (wr_en && address == ADDR_FALL) ? wr_data[W-1:0] : '0;
        rise_d   = (rise_q & ~rise_clr) | rise_set;
        fall_d   = (fall_q & ~fall_clr) | fall_set;
        mask_d   = (wr_en && address == ADDR_MASK) ? wr_data[W-1:0] : mask_q;
    end

    // Register state.
    always_ff @(posedge clock) begin
        if (reset) begin
            rise_q <= '0;
            fall_q <= '0;
            mask_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
            mask_q <= mask_d;
        end
    end

    // Read mux; always live so software sees current state without a strobe.
    always_comb begin
        rd_data = '0;
        case (address)
            ADDR_LEVEL: rd_data = DATA_W'(lvl);
            ADDR_RISE:  rd_data = DATA_W'(rise_q);
            ADDR_FALL:  rd_data = DATA_W'(fall_q);
            ADDR_MASK:  rd_data = DATA_W'(mask_q);
            default:    rd_data = '0;
        endcase
    end

    assign irq = |((rise_q | fall_q) & mask_q);

    // Read strobe and the upper write-data bits carry no meaning for this block.
    logic unused_inputs;
    assign unused_inputs = ^{read, wr_data};

endmodule : gpi_edge

// File: tb/tb_gpi_edge.sv
module tb_gpi_edge;

    localparam int W  = 16;
    localparam int DB = 4;
`ifdef GPI_EDGE_DEBOUNCE_EN
    localparam int LAT   = 2 + DB;
    localparam int PULSE = 10;
`else
    localparam int LAT   = 3;
    localparam int PULSE = 1;
`endif

    localparam logic [4:0] A_LEVEL = 5'h00;
    localparam logic [4:0] A_RISE  = 5'h01;
    localparam logic [4:0] A_FALL  = 5'h02;
    localparam logic [4:0] A_MASK  = 5'h03;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  address;
    logic [31:0] rd_data;
    logic [31:0] wr_data;
    logic        read;
    logic        write;
    logic        cs;
    logic [W-1:0] data_in;
    logic        irq;

    gpi_edge #(.W(W), .DB_CYCLES(DB)) dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .rd_data (rd_data),
        .wr_data (wr_data),
        .read    (read),
        .write   (write),
        .cs      (cs),
        .data_in (data_in),
        .irq     (irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    // Monitor: every read cycle presents rd_data/irq; pop and compare.
    always @(negedge clock) begin
        if (read) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_underflow: read of addr %0h with no expected entry", address);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if (rd_data !== e.data) begin
                    n_err++;
                    $display("FAIL %s rd_data addr=%0h: got %08h expected %08h", e.name, e.addr, rd_data, e.data);
                end
                n_cmp++;
                if (irq !== e.irq) begin
                    n_err++;
                    $display("FAIL %s irq: got %0b expected %0b", e.name, irq, e.irq);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_read(input string name, input logic [4:0] a, input logic [31:0] exp_d, input logic exp_i);
        exp_t x;
        x.name = name; x.addr = a; x.data = exp_d; x.irq = exp_i;
        sb.push_back(x);
        address = a;
        read    = 1'b1;
        tick(1);
        read    = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic sel);
        address = a;
        wr_data = d;
        cs      = sel;
        write   = 1'b1;
        tick(1);
        write   = 1'b0;
        cs      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; address = '0; wr_data = '0; read = 1'b0; write = 1'b0; cs = 1'b0; data_in = '0;
        tick(3);
        do_read("rst_level", A_LEVEL, 32'h0, 1'b0);
        do_read("rst_rise",  A_RISE,  32'h0, 1'b0);
        do_read("rst_fall",  A_FALL,  32'h0, 1'b0);
        do_read("rst_mask",  A_MASK,  32'h0, 1'b0);
        reset = 1'b0;
        tick(4);

        // Level latency and rise capture, mask still zero
        data_in = 16'h0005;
        tick(LAT - 1);
        do_read("level_early", A_LEVEL, 32'h0, 1'b0);
        do_read("level_5",     A_LEVEL, 32'h5, 1'b0);
        do_read("rise_5",      A_RISE,  32'h5, 1'b0);
        do_read("fall_0",      A_FALL,  32'h0, 1'b0);

        // Partial and full W1C of rise
        do_write(A_RISE, 32'h0000_0004, 1'b1);
        do_read("rise_partial_w1c", A_RISE, 32'h1, 1'b0);
        do_write(A_RISE, 32'hFFFF_FFFF, 1'b1);
        do_read("rise_all_w1c", A_RISE, 32'h0, 1'b0);

        // Mask write, upper data bits ignored
        do_write(A_MASK, 32'hFFFF_0001, 1'b1);
        do_read("mask_1", A_MASK, 32'h1, 1'b0);

        // Falling bit0 raises irq, W1C drops it
        data_in = 16'h0004;
        tick(LAT - 1);
        do_read("fall_early", A_FALL, 32'h0, 1'b0);
        do_read("fall_1",     A_FALL, 32'h1, 1'b1);
        do_write(A_FALL, 32'h0000_0001, 1'b1);
        do_read("fall_cleared", A_FALL,  32'h0, 1'b0);
        do_read("level_4",      A_LEVEL, 32'h4, 1'b0);

        // Set wins over same-cycle clear
        data_in = 16'h0005;
        tick(LAT + 1);
        do_read("rise_again", A_RISE, 32'h1, 1'b1);
        do_write(A_RISE, 32'h0000_0001, 1'b1);
        do_read("rise_again_clr", A_RISE, 32'h0, 1'b0);
        data_in = 16'h0004;
        tick(LAT - 1);
        do_write(A_FALL, 32'h0000_0001, 1'b1);
        do_read("fall_set_wins", A_FALL, 32'h1, 1'b1);

        // Unmapped addresses and writes without cs
        do_read("addr07", 5'h07, 32'h0, 1'b1);
        do_read("addr1f", 5'h1F, 32'h0, 1'b1);
        do_write(5'h07, 32'hFFFF_FFFF, 1'b1);
        do_write(5'h1F, 32'hFFFF_FFFF, 1'b1);
        do_write(A_MASK, 32'h0000_FFFF, 1'b0);
        do_write(A_FALL, 32'h0000_FFFF, 1'b0);
        do_read("mask_kept",  A_MASK,  32'h1, 1'b1);
        do_read("fall_kept",  A_FALL,  32'h1, 1'b1);
        do_read("rise_kept",  A_RISE,  32'h0, 1'b1);
        do_read("level_kept", A_LEVEL, 32'h4, 1'b1);
        do_write(A_FALL, 32'hFFFF_FFFF, 1'b1);
        do_read("fall_clr_all", A_FALL, 32'h0, 1'b0);
        do_write(A_MASK, 32'hABCD_0003, 1'b1);
        do_read("mask_3", A_MASK, 32'h3, 1'b0);

`ifdef GPI_EDGE_DEBOUNCE_EN
        // Short glitch on bit3 must be filtered out
        data_in = 16'h000C;
        tick(2);
        data_in = 16'h0004;
        tick(LAT + 4);
        do_read("glitch_level", A_LEVEL, 32'h4, 1'b0);
        do_read("glitch_rise",  A_RISE,  32'h0, 1'b0);
`endif
        // Pulse on bit3 long enough to pass the filter
        data_in = 16'h000C;
        tick(PULSE);
        data_in = 16'h0004;
        tick(LAT + 4);
        do_read("pulse_rise",  A_RISE,  32'h8, 1'b0);
        do_read("pulse_fall",  A_FALL,  32'h8, 1'b0);
        do_read("pulse_level", A_LEVEL, 32'h4, 1'b0);

        // Reset mid-operation with pending edges and full mask
        data_in = 16'h0000;
        tick(LAT + 2);
        do_write(A_RISE, 32'hFFFF_FFFF, 1'b1);
        do_write(A_FALL, 32'hFFFF_FFFF, 1'b1);
        data_in = 16'h00FF;
        tick(LAT + 2);
        do_read("rise_ff", A_RISE, 32'hFF, 1'b1);
        do_write(A_MASK, 32'h0000_FFFF, 1'b1);
        do_read("mask_ffff", A_MASK, 32'hFFFF, 1'b1);
        data_in = 16'h8000;
        tick(3);
        reset = 1'b1;
        tick(1);
        do_read("mid_rst_level", A_LEVEL, 32'h0, 1'b0);
        do_read("mid_rst_rise",  A_RISE,  32'h0, 1'b0);
        do_read("mid_rst_fall",  A_FALL,  32'h0, 1'b0);
        do_read("mid_rst_mask",  A_MASK,  32'h0, 1'b0);
        reset = 1'b0;
        tick(LAT - 1);
        do_read("post_rst_early", A_RISE,  32'h0,    1'b0);
        do_read("post_rst_rise",  A_RISE,  32'h8000, 1'b0);
        do_read("post_rst_level", A_LEVEL, 32'h8000, 1'b0);
        do_read("post_rst_fall",  A_FALL,  32'h0,    1'b0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) tick(1);
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_gpi_edge
